// File: rtl/servo_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : servo_move_sequencer
//  Description : Command-driven move sequencer for the arm's hobby servos.
//                Accepts one move at a time (channel index + target pulse
//                width), ramps the selected channel's duty count toward the
//                target by at most STEP once per PWM frame, holds for
//                SETTLE_FRAMES frames, then pulses done. The duty/period
//                outputs feed NUM_SERVOS downstream pwm_servos instances.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock
//    res         in   asynchronous active-low reset
//    cmd_valid   in   move command present
//    cmd_ready   out  command can be accepted (high only while idle)
//    cmd_idx     in   servo channel to move (IDX_W bits)
//    cmd_target  in   requested duty count (clamped to MIN_D..MAX_D)
//    d_out       out  per-channel duty counts, channel i at [32*i+31:32*i]
//    t_out       out  PWM period, constant PERIOD
//    busy        out  move in progress (ramping or settling)
//    done        out  one-cycle pulse when a move completes
//    err         out  one-cycle pulse on a command with out-of-range index
// ============================================================================
module servo_move_sequencer #(
  parameter int NUM_SERVOS    = 4,
  parameter int PERIOD        = 2000000,
  parameter int MIN_D         = 100000,
  parameter int MAX_D         = 200000,
  parameter int CENTER_D      = 150000,
  parameter int STEP          = 2000,
  parameter int SETTLE_FRAMES = 10,
  // Index port width; may be widened so out-of-range indices are expressible.
  parameter int IDX_W         = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [IDX_W-1:0]        cmd_idx,
  input  logic [31:0]             cmd_target,
  output logic [32*NUM_SERVOS-1:0] d_out,
  output logic [31:0]             t_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  // Width needed to select among the real channels.
  localparam int SEL_W = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1;

  localparam logic [31:0]    c_PERIOD   = 32'(PERIOD);
  localparam logic [31:0]    c_FRM_LAST = 32'(PERIOD - 1);
  localparam logic [31:0]    c_MIN_D    = 32'(MIN_D);
  localparam logic [31:0]    c_MAX_D    = 32'(MAX_D);
  localparam logic [31:0]    c_CENTER_D = 32'(CENTER_D);
  localparam logic [31:0]    c_STEP     = 32'(STEP);
  localparam logic [31:0]    c_SETTLE   = 32'(SETTLE_FRAMES);
  localparam logic [IDX_W:0] c_NUM_EXT  = (IDX_W + 1)'(NUM_SERVOS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAMP   = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic [31:0]      r_frm;
  logic [31:0]      r_duty [NUM_SERVOS];
  logic [SEL_W-1:0] r_idx;
  logic [31:0]      r_tgt;
  logic [31:0]      r_settle;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_tick;
  logic             w_idx_bad;
  logic [31:0]      w_tgt_clamped;
  logic [31:0]      w_cmd_cur;
  logic [31:0]      w_cur;
  logic [31:0]      w_diff;
  logic [31:0]      w_next;
  logic [31:0]      w_settle_inc;

  // --------------------------------------------------------------------------
  // Free-running frame counter; never restarted by commands so duty updates
  // always land on the PWM period boundary.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_frm <= '0;
    end else if (r_frm == c_FRM_LAST) begin
      r_frm <= '0;
    end else begin
      r_frm <= r_frm + 32'd1;
    end
  end

  assign w_tick = (r_frm == c_FRM_LAST);

  // --------------------------------------------------------------------------
  // Command decode: range check, target clamp, current duty of the
  // addressed channel (used to detect an already-satisfied target).
  // --------------------------------------------------------------------------
  assign w_idx_bad = ({1'b0, cmd_idx} >= c_NUM_EXT);

  always_comb begin
    w_tgt_clamped = cmd_target;
    if (cmd_target < c_MIN_D) begin
      w_tgt_clamped = c_MIN_D;
    end else if (cmd_target > c_MAX_D) begin
      w_tgt_clamped = c_MAX_D;
    end
  end

  always_comb begin
    w_cmd_cur = r_duty[0];
    for (int i = 0; i < NUM_SERVOS; i++) begin
      if ({1'b0, cmd_idx} == (IDX_W + 1)'(i)) begin
        w_cmd_cur = r_duty[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Ramp step for the channel under move: approach target by at most STEP.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cur = r_duty[0];
    for (int i = 0; i < NUM_SERVOS; i++) begin
      if (r_idx == SEL_W'(i)) begin
        w_cur = r_duty[i];
      end
    end
  end

  always_comb begin
    w_diff = '0;
    w_next = w_cur;
    if (r_tgt > w_cur) begin
      w_diff = r_tgt - w_cur;
      w_next = w_cur + ((w_diff > c_STEP) ? c_STEP : w_diff);
    end else if (r_tgt < w_cur) begin
      w_diff = w_cur - r_tgt;
      w_next = w_cur - ((w_diff > c_STEP) ? c_STEP : w_diff);
    end
  end

  assign w_settle_inc = r_settle + 32'd1;

  // --------------------------------------------------------------------------
  // Move FSM with registered status outputs and duty registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state  <= S_IDLE;
      for (int i = 0; i < NUM_SERVOS; i++) begin
        r_duty[i] <= c_CENTER_D;
      end
      r_idx    <= '0;
      r_tgt    <= c_CENTER_D;
      r_settle <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (w_idx_bad) begin
              r_err <= 1'b1;
            end else begin
              r_idx    <= cmd_idx[SEL_W-1:0];
              r_tgt    <= w_tgt_clamped;
              r_settle <= '0;
              r_ready  <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= (w_tgt_clamped == w_cmd_cur) ? S_SETTLE : S_RAMP;
            end
          end
        end

        S_RAMP: begin
          if (w_tick) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
              if (r_idx == SEL_W'(i)) begin
                r_duty[i] <= w_next;
              end
            end
            if (w_next == r_tgt) begin
              r_settle <= '0;
              r_state  <= S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          if (c_SETTLE == 32'd0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_tick) begin
            r_settle <= w_settle_inc;
            if (w_settle_inc == c_SETTLE) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output packing
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_SERVOS; gi++) begin : g_pack
      assign d_out[32*gi +: 32] = r_duty[gi];
    end
  endgenerate

  assign t_out     = c_PERIOD;
  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_servo_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_move_sequencer
//  Description : Directed self-checking bench for servo_move_sequencer with
//                PERIOD=100, MIN_D=20, MAX_D=80, CENTER_D=50, STEP=10,
//                SETTLE_FRAMES=2 and a 3-bit index port so that out-of-range
//                indices can be driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_move_sequencer;

  logic         clk = 1'b0;
  logic         res;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_idx;
  logic [31:0]  cmd_target;
  logic [127:0] d_out;
  logic [31:0]  t_out;
  logic         busy;
  logic         done;
  logic         err;

  int nvec  = 0;
  int nfail = 0;
  int cyc;
  int exp_d [4];

  always #5 clk = ~clk;

  servo_move_sequencer #(
    .NUM_SERVOS   (4),
    .PERIOD       (100),
    .MIN_D        (20),
    .MAX_D        (80),
    .CENTER_D     (50),
    .STEP         (10),
    .SETTLE_FRAMES(2),
    .IDX_W        (3)
  ) u_dut (
    .clk       (clk),
    .res       (res),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_idx   (cmd_idx),
    .cmd_target(cmd_target),
    .d_out     (d_out),
    .t_out     (t_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Edges since reset release; a frame tick update lands on every edge
  // where this becomes a multiple of 100.
  always @(posedge clk or negedge res) begin
    if (!res) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [31:0] ch(input int i);
    return d_out[32*i +: 32];
  endfunction

  // Advance to the negedge just after the next frame-tick edge.
  task automatic wait_tick(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (cyc % 100 == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL %s tick_timeout: no frame tick within 150 cycles (cyc=%0d)", name, cyc);
      nfail++;
      nvec++;
    end
  endtask

  task automatic send(input int idx, input int tgt);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_idx    = 3'(idx);
    cmd_target = 32'(tgt);
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  // One complete move: ramp ticks against the channel model, two settle
  // ticks, one-cycle done pulse, return to ready.
  task automatic test_move(input string name, input int idx, input int tgt,
                           input int exp_tgt, input bit check_first_tick);
    send(idx, tgt);
    nvec++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      $display("FAIL %s accept: busy=%b ready=%b, need busy=1 ready=0", name, busy, cmd_ready);
      nfail++;
    end

    if (check_first_tick) begin
      for (int k = 0; k < 120 && cyc != 99; k++) @(negedge clk);
      nvec++;
      if (ch(idx) !== 32'(exp_d[idx]) || cyc != 99) begin
        $display("FAIL %s pre_tick: cyc=%0d ch=%0d, need cyc=99 ch=%0d", name, cyc, ch(idx), exp_d[idx]);
        nfail++;
      end
    end

    for (int n = 0; n < 12 && exp_d[idx] != exp_tgt; n++) begin
      wait_tick(name);
      if (exp_tgt > exp_d[idx]) exp_d[idx] += (exp_tgt - exp_d[idx] > 10) ? 10 : exp_tgt - exp_d[idx];
      else                      exp_d[idx] -= (exp_d[idx] - exp_tgt > 10) ? 10 : exp_d[idx] - exp_tgt;
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (ch(i) !== 32'(exp_d[i])) begin
          $display("FAIL %s ramp ch%0d: got %0d, need %0d (cyc=%0d)", name, i, ch(i), exp_d[i], cyc);
          nfail++;
        end
      end
      nvec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        $display("FAIL %s ramp_busy: busy=%b done=%b, need 1/0", name, busy, done);
        nfail++;
      end
    end

    wait_tick(name);
    nvec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL %s settle1: done=%b busy=%b, need 0/1", name, done, busy);
      nfail++;
    end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (ch(i) !== 32'(exp_d[i])) begin
        $display("FAIL %s settle ch%0d: got %0d, need %0d", name, i, ch(i), exp_d[i]);
        nfail++;
      end
    end

    wait_tick(name);
    nvec++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      $display("FAIL %s done_pulse: done=%b busy=%b ready=%b, need 1/0/0", name, done, busy, cmd_ready);
      nfail++;
    end

    @(negedge clk);
    nvec++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL %s after_done: done=%b ready=%b busy=%b, need 0/1/0", name, done, cmd_ready, busy);
      nfail++;
    end
  endtask

  task automatic test_reset();
    res        = 1'b0;
    cmd_valid  = 1'b0;
    cmd_idx    = '0;
    cmd_target = '0;
    #23;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (ch(i) !== 32'd50) begin
        $display("FAIL reset ch%0d: got %0d, need 50", i, ch(i));
        nfail++;
      end
      exp_d[i] = 50;
    end
    nvec++;
    if (t_out !== 32'd100 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      $display("FAIL reset_status: t=%0d ready=%b busy=%b done=%b err=%b, need 100/1/0/0/0",
               t_out, cmd_ready, busy, done, err);
      nfail++;
    end
    res = 1'b1;
  endtask

  task automatic test_ramp_up();
    test_move("ramp_up", 1, 80, 80, 1'b1);
    nvec++;
    if (ch(1) !== 32'd80 || ch(0) !== 32'd50 || ch(2) !== 32'd50 || ch(3) !== 32'd50) begin
      $display("FAIL ramp_up_final: ch0..3=%0d,%0d,%0d,%0d, need 50,80,50,50", ch(0), ch(1), ch(2), ch(3));
      nfail++;
    end
  endtask

  task automatic test_clamp();
    test_move("clamp_low", 2, 5, 20, 1'b0);
    nvec++;
    if (ch(2) !== 32'd20) begin
      $display("FAIL clamp_low_final: ch2=%0d, need 20", ch(2));
      nfail++;
    end
    test_move("clamp_high", 0, 95, 80, 1'b0);
    nvec++;
    if (ch(0) !== 32'd80) begin
      $display("FAIL clamp_high_final: ch0=%0d, need 80", ch(0));
      nfail++;
    end
  endtask

  task automatic test_equal_target();
    test_move("equal_target", 3, 50, 50, 1'b0);
    nvec++;
    if (ch(3) !== 32'd50) begin
      $display("FAIL equal_target_final: ch3=%0d, need 50", ch(3));
      nfail++;
    end
  endtask

  task automatic test_bad_index();
    send(5, 60);
    nvec++;
    if (err !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL bad_index_pulse: err=%b ready=%b busy=%b, need 1/1/0", err, cmd_ready, busy);
      nfail++;
    end
    @(negedge clk);
    nvec++;
    if (err !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL bad_index_after: err=%b ready=%b, need 0/1", err, cmd_ready);
      nfail++;
    end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (ch(i) !== 32'(exp_d[i])) begin
        $display("FAIL bad_index ch%0d: got %0d, need %0d", i, ch(i), exp_d[i]);
        nfail++;
      end
    end
  endtask

  task automatic test_ignore_during_ramp();
    bit seen_done;
    bit bad;
    send(1, 60);
    // Competing command held for a while during the ramp, then dropped.
    cmd_valid  = 1'b1;
    cmd_idx    = 3'd2;
    cmd_target = 32'd80;
    repeat (30) @(negedge clk);
    cmd_valid  = 1'b0;
    seen_done  = 1'b0;
    for (int k = 0; k < 600 && !seen_done; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    nvec++;
    if (!seen_done) begin
      $display("FAIL ignore_ramp done_timeout: done not seen within 600 cycles");
      nfail++;
    end
    exp_d[1] = 60;
    nvec++;
    if (ch(1) !== 32'd60 || ch(2) !== 32'(exp_d[2])) begin
      $display("FAIL ignore_ramp_final: ch1=%0d ch2=%0d, need 60 %0d", ch(1), ch(2), exp_d[2]);
      nfail++;
    end
    bad = 1'b0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || ch(2) !== 32'(exp_d[2])) bad = 1'b1;
    end
    nvec++;
    if (bad) begin
      $display("FAIL ignore_ramp_second_move: busy=%b ready=%b ch2=%0d, need 0/1/%0d",
               busy, cmd_ready, ch(2), exp_d[2]);
      nfail++;
    end
  endtask

  task automatic test_reset_mid_move();
    bit bad;
    send(1, 80);
    wait_tick("reset_mid");
    nvec++;
    if (ch(1) !== 32'd70) begin
      $display("FAIL reset_mid pre: ch1=%0d, need 70", ch(1));
      nfail++;
    end
    @(negedge clk);
    #2 res = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (ch(i) !== 32'd50) begin
        $display("FAIL reset_mid ch%0d: got %0d, need 50", i, ch(i));
        nfail++;
      end
      exp_d[i] = 50;
    end
    nvec++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      $display("FAIL reset_mid_status: busy=%b ready=%b done=%b, need 0/1/0", busy, cmd_ready, done);
      nfail++;
    end
    repeat (3) @(negedge clk);
    res = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    nvec++;
    if (bad) begin
      $display("FAIL reset_mid_no_done: done=%b busy=%b, need 0/0 throughout", done, busy);
      nfail++;
    end
    test_move("post_reset", 0, 30, 30, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp();
    test_equal_target();
    test_bad_index();
    test_ignore_during_ramp();
    test_reset_mid_move();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
